// File: rtl/id_ex_forward_pkg.sv
// Shared definitions for the ID/EX pipeline register with operand forwarding.
//   DATA_W_DEF : default datapath width
//   RN_W       : register-number width
//   ALUC_W     : ALU-control width
//   fwd_sel_e  : operand source select code reported by fwd_sel
package id_ex_forward_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RN_W       = 5;
    localparam int ALUC_W     = 4;

    typedef enum logic [2:0] {
        FWD_RF      = 3'd0,
        FWD_EX      = 3'd1,
        FWD_MEM_ALU = 3'd2,
        FWD_MEM_MDO = 3'd3,
        FWD_WB      = 3'd4
    } fwd_sel_e;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding selector. Picks the youngest in-flight producer of
// register rn_i, falling back to the register-file read value.
// Ports:
//   rn_i                         source register number
//   rf_i                         register-file read data for rn_i
//   ex_hit_en_i, ex_wn_i, ex_res_i
//                                EX stage may forward (valid, writes, not a load)
//   mem_we_i, mem_m2reg_i, mem_wn_i, mem_alu_i, mem_mdo_i
//                                MEM stage destination and results
//   wb_we_i, wb_wn_i, wb_d_i     write-back port
//   sel_o                        chosen source
//   operand_o                    forwarded operand value
module fwd_sel
    import id_ex_forward_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [RN_W-1:0]   rn_i,
    input  logic [DATA_W-1:0] rf_i,
    input  logic              ex_hit_en_i,
    input  logic [RN_W-1:0]   ex_wn_i,
    input  logic [DATA_W-1:0] ex_res_i,
    input  logic              mem_we_i,
    input  logic              mem_m2reg_i,
    input  logic [RN_W-1:0]   mem_wn_i,
    input  logic [DATA_W-1:0] mem_alu_i,
    input  logic [DATA_W-1:0] mem_mdo_i,
    input  logic              wb_we_i,
    input  logic [RN_W-1:0]   wb_wn_i,
    input  logic [DATA_W-1:0] wb_d_i,
    output fwd_sel_e          sel_o,
    output logic [DATA_W-1:0] operand_o
);

    // Register 0 is hard-wired, so it never matches any producer.
    always_comb begin
        sel_o = FWD_RF;
        if (rn_i != '0) begin
            if (ex_hit_en_i && (ex_wn_i == rn_i)) begin
                sel_o = FWD_EX;
            end else if (mem_we_i && (mem_wn_i == rn_i)) begin
                sel_o = mem_m2reg_i ? FWD_MEM_MDO : FWD_MEM_ALU;
            end else if (wb_we_i && (wb_wn_i == rn_i)) begin
                // Register file is written on the same edge, so its read
                // port still shows the old value this cycle.
                sel_o = FWD_WB;
            end
        end
    end

    always_comb begin
        case (sel_o)
            FWD_EX:      operand_o = ex_res_i;
            FWD_MEM_ALU: operand_o = mem_alu_i;
            FWD_MEM_MDO: operand_o = mem_mdo_i;
            FWD_WB:      operand_o = wb_d_i;
            default:     operand_o = rf_i;
        endcase
    end

endmodule

// File: rtl/id_ex_forward.sv
// ID/EX pipeline register with operand forwarding and load-use stall.
// Ports:
//   clk, clrn                         clock, async active-low reset
//   id_*                              decoded instruction in ID
//   ex_res                            result of the instruction now in EX
//   mem_*                             destination/results of the MEM stage
//   wb_wn, wb_we, wb_d                write-back port (same as RF write)
//   ex_flush                          squash the instruction entering EX
//   stall                             hold PC and IF/ID this cycle
//   ex_*                              registered ID/EX contents
module id_ex_forward
    import id_ex_forward_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              id_valid,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic [RN_W-1:0]   id_rna,
    input  logic [RN_W-1:0]   id_rnb,
    input  logic [RN_W-1:0]   id_wn,
    input  logic [DATA_W-1:0] id_qa,
    input  logic [DATA_W-1:0] id_qb,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_we,
    input  logic              id_m2reg,
    input  logic              id_aluimm,
    input  logic [ALUC_W-1:0] id_aluc,
    input  logic [DATA_W-1:0] ex_res,
    input  logic [RN_W-1:0]   mem_wn,
    input  logic              mem_we,
    input  logic              mem_m2reg,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic [DATA_W-1:0] mem_mdo,
    input  logic [RN_W-1:0]   wb_wn,
    input  logic              wb_we,
    input  logic [DATA_W-1:0] wb_d,
    input  logic              ex_flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_we,
    output logic              ex_m2reg,
    output logic              ex_aluimm,
    output logic [RN_W-1:0]   ex_wn,
    output logic [ALUC_W-1:0] ex_aluc,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm
);

    logic              ex_valid_q;
    logic              ex_we_q;
    logic              ex_m2reg_q;
    logic              ex_aluimm_q;
    logic [RN_W-1:0]   ex_wn_q;
    logic [ALUC_W-1:0] ex_aluc_q;
    logic [DATA_W-1:0] ex_a_q;
    logic [DATA_W-1:0] ex_b_q;
    logic [DATA_W-1:0] ex_imm_q;

    logic              ex_hit_en;
    logic              load_use;
    logic              bubble;
    fwd_sel_e          sel_a;
    fwd_sel_e          sel_b;
    logic [DATA_W-1:0] fwd_a_d;
    logic [DATA_W-1:0] fwd_b_d;

    // A load in EX has no data yet, so it can only be forwarded from MEM.
    assign ex_hit_en = ex_valid_q & ex_we_q & ~ex_m2reg_q;

    fwd_sel #(.DATA_W(DATA_W)) u_fwd_a (
        .rn_i        (id_rna),
        .rf_i        (id_qa),
        .ex_hit_en_i (ex_hit_en),
        .ex_wn_i     (ex_wn_q),
        .ex_res_i    (ex_res),
        .mem_we_i    (mem_we),
        .mem_m2reg_i (mem_m2reg),
        .mem_wn_i    (mem_wn),
        .mem_alu_i   (mem_alu),
        .mem_mdo_i   (mem_mdo),
        .wb_we_i     (wb_we),
        .wb_wn_i     (wb_wn),
        .wb_d_i      (wb_d),
        .sel_o       (sel_a),
        .operand_o   (fwd_a_d)
    );

    fwd_sel #(.DATA_W(DATA_W)) u_fwd_b (
        .rn_i        (id_rnb),
        .rf_i        (id_qb),
        .ex_hit_en_i (ex_hit_en),
        .ex_wn_i     (ex_wn_q),
        .ex_res_i    (ex_res),
        .mem_we_i    (mem_we),
        .mem_m2reg_i (mem_m2reg),
        .mem_wn_i    (mem_wn),
        .mem_alu_i   (mem_alu),
        .mem_mdo_i   (mem_mdo),
        .wb_we_i     (wb_we),
        .wb_wn_i     (wb_wn),
        .wb_d_i      (wb_d),
        .sel_o       (sel_b),
        .operand_o   (fwd_b_d)
    );

    // Select codes are kept for observability in simulation only.
    logic unused_sel;
    assign unused_sel = ^{sel_a, sel_b};

    // A squashed slot cannot cause a hazard, so flush overrides stall.
    assign load_use = id_valid & ex_valid_q & ex_m2reg_q & (ex_wn_q != '0)
                    & ((id_use_a & (ex_wn_q == id_rna)) |
                       (id_use_b & (ex_wn_q == id_rnb)));
    assign stall    = load_use & ~ex_flush;
    assign bubble   = ex_flush | ~id_valid | stall;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ex_valid_q  <= 1'b0;
            ex_we_q     <= 1'b0;
            ex_m2reg_q  <= 1'b0;
            ex_aluimm_q <= 1'b0;
            ex_wn_q     <= '0;
            ex_aluc_q   <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_imm_q    <= '0;
        end else if (bubble) begin
            ex_valid_q  <= 1'b0;
            ex_we_q     <= 1'b0;
            ex_m2reg_q  <= 1'b0;
            ex_aluimm_q <= 1'b0;
            ex_wn_q     <= '0;
            ex_aluc_q   <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_imm_q    <= '0;
        end else begin
            ex_valid_q  <= 1'b1;
            ex_we_q     <= id_we;
            ex_m2reg_q  <= id_m2reg;
            ex_aluimm_q <= id_aluimm;
            ex_wn_q     <= id_wn;
            ex_aluc_q   <= id_aluc;
            ex_a_q      <= fwd_a_d;
            ex_b_q      <= fwd_b_d;
            ex_imm_q    <= id_imm;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_we     = ex_we_q;
    assign ex_m2reg  = ex_m2reg_q;
    assign ex_aluimm = ex_aluimm_q;
    assign ex_wn     = ex_wn_q;
    assign ex_aluc   = ex_aluc_q;
    assign ex_a      = ex_a_q;
    assign ex_b      = ex_b_q;
    assign ex_imm    = ex_imm_q;

endmodule

// File: tb/tb_id_ex_forward.sv
// Self-checking bench for id_ex_forward: random traffic against a behavioural
// pipeline model, followed by directed forwarding, hazard and reset scenarios.
module tb_id_ex_forward;

    logic        clk;
    logic        clrn;
    logic        id_valid, id_use_a, id_use_b;
    logic [4:0]  id_rna, id_rnb, id_wn;
    logic [31:0] id_qa, id_qb, id_imm;
    logic        id_we, id_m2reg, id_aluimm;
    logic [3:0]  id_aluc;
    logic [31:0] ex_res;
    logic [4:0]  mem_wn;
    logic        mem_we, mem_m2reg;
    logic [31:0] mem_alu, mem_mdo;
    logic [4:0]  wb_wn;
    logic        wb_we;
    logic [31:0] wb_d;
    logic        ex_flush;
    logic        stall;
    logic        ex_valid, ex_we, ex_m2reg, ex_aluimm;
    logic [4:0]  ex_wn;
    logic [3:0]  ex_aluc;
    logic [31:0] ex_a, ex_b, ex_imm;

    id_ex_forward dut (
        .clk(clk), .clrn(clrn),
        .id_valid(id_valid), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .id_rna(id_rna), .id_rnb(id_rnb), .id_wn(id_wn),
        .id_qa(id_qa), .id_qb(id_qb), .id_imm(id_imm),
        .id_we(id_we), .id_m2reg(id_m2reg), .id_aluimm(id_aluimm), .id_aluc(id_aluc),
        .ex_res(ex_res), .mem_wn(mem_wn), .mem_we(mem_we), .mem_m2reg(mem_m2reg),
        .mem_alu(mem_alu), .mem_mdo(mem_mdo),
        .wb_wn(wb_wn), .wb_we(wb_we), .wb_d(wb_d),
        .ex_flush(ex_flush), .stall(stall),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_m2reg(ex_m2reg), .ex_aluimm(ex_aluimm),
        .ex_wn(ex_wn), .ex_aluc(ex_aluc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model of the instruction currently sitting in EX.
    logic        m_valid, m_we, m_m2reg, m_aluimm;
    logic [4:0]  m_wn;
    logic [3:0]  m_aluc;
    logic [31:0] m_a, m_b, m_imm;

    task automatic model_clear();
        m_valid = 0; m_we = 0; m_m2reg = 0; m_aluimm = 0;
        m_wn = 0; m_aluc = 0; m_a = 0; m_b = 0; m_imm = 0;
    endtask

    // Value the instruction in ID should see for register rn.
    function automatic logic [31:0] operand(input logic [4:0] rn, input logic [31:0] rf);
        if (rn == 0) return rf;
        if (m_valid && m_we && !m_m2reg && m_wn == rn) return ex_res;
        if (mem_we && mem_wn == rn) return mem_m2reg ? mem_mdo : mem_alu;
        if (wb_we && wb_wn == rn) return wb_d;
        return rf;
    endfunction

    function automatic logic exp_stall();
        if (!id_valid || ex_flush) return 1'b0;
        if (!(m_valid && m_m2reg) || m_wn == 0) return 1'b0;
        return (id_use_a && m_wn == id_rna) || (id_use_b && m_wn == id_rnb);
    endfunction

    task automatic check_ex(input string tag);
        chk({tag, ".valid"},  {31'b0, ex_valid},  {31'b0, m_valid});
        chk({tag, ".we"},     {31'b0, ex_we},     {31'b0, m_we});
        chk({tag, ".m2reg"},  {31'b0, ex_m2reg},  {31'b0, m_m2reg});
        chk({tag, ".aluimm"}, {31'b0, ex_aluimm}, {31'b0, m_aluimm});
        chk({tag, ".wn"},     {27'b0, ex_wn},     {27'b0, m_wn});
        chk({tag, ".aluc"},   {28'b0, ex_aluc},   {28'b0, m_aluc});
        chk({tag, ".a"},      ex_a,   m_a);
        chk({tag, ".b"},      ex_b,   m_b);
        chk({tag, ".imm"},    ex_imm, m_imm);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic run_cycle(input string tag);
        logic s, bub;
        logic [31:0] na, nb;
        #1;
        s = exp_stall();
        chk({tag, ".stall"}, {31'b0, stall}, {31'b0, s});
        bub = ex_flush || !id_valid || s;
        na  = operand(id_rna, id_qa);
        nb  = operand(id_rnb, id_qb);
        @(posedge clk);
        #1;
        if (bub) begin
            model_clear();
        end else begin
            m_valid = 1; m_we = id_we; m_m2reg = id_m2reg; m_aluimm = id_aluimm;
            m_wn = id_wn; m_aluc = id_aluc; m_a = na; m_b = nb; m_imm = id_imm;
        end
        check_ex(tag);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_use_a = 0; id_use_b = 0;
        id_rna = 0; id_rnb = 0; id_wn = 0;
        id_qa = 0; id_qb = 0; id_imm = 0;
        id_we = 0; id_m2reg = 0; id_aluimm = 0; id_aluc = 0;
        ex_res = 0; mem_wn = 0; mem_we = 0; mem_m2reg = 0; mem_alu = 0; mem_mdo = 0;
        wb_wn = 0; wb_we = 0; wb_d = 0; ex_flush = 0;
    endtask

    task automatic random_inputs();
        id_valid  = ($urandom_range(0, 9) < 8);
        id_use_a  = $urandom_range(0, 1);
        id_use_b  = $urandom_range(0, 1);
        id_rna    = 5'($urandom_range(0, 7));
        id_rnb    = 5'($urandom_range(0, 7));
        id_wn     = 5'($urandom_range(0, 7));
        id_qa     = $urandom;
        id_qb     = $urandom;
        id_imm    = $urandom;
        id_we     = $urandom_range(0, 1);
        id_m2reg  = ($urandom_range(0, 2) == 0);
        id_aluimm = $urandom_range(0, 1);
        id_aluc   = 4'($urandom_range(0, 15));
        ex_res    = $urandom;
        mem_wn    = 5'($urandom_range(0, 7));
        mem_we    = $urandom_range(0, 1);
        mem_m2reg = $urandom_range(0, 1);
        mem_alu   = $urandom;
        mem_mdo   = $urandom;
        wb_wn     = 5'($urandom_range(0, 7));
        wb_we     = $urandom_range(0, 1);
        wb_d      = $urandom;
        ex_flush  = ($urandom_range(0, 9) == 0);
    endtask

    // Load an instruction into EX that writes register wn.
    task automatic load_producer(input logic [4:0] wn, input logic m2reg);
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_we = 1; id_m2reg = m2reg; id_wn = wn;
        run_cycle("load");
    endtask

    initial begin
        idle_inputs();
        model_clear();
        clrn = 0;
        #2;
        check_ex("reset");
        chk("reset.stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        clrn = 1;

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            random_inputs();
            run_cycle("rand");
        end

        // EX forwarding into operand a.
        load_producer(5'd3, 1'b0);
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_rna = 3; id_qa = 32'h3; ex_res = 32'h10;
        run_cycle("ex_fwd");
        chk("ex_fwd.a", ex_a, 32'h10);

        // Priority EX > MEM > WB on operand b.
        load_producer(5'd4, 1'b0);
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_rnb = 4; id_qb = 32'h4; ex_res = 32'hAA;
        mem_we = 1; mem_wn = 4; mem_alu = 32'hBB; wb_we = 1; wb_wn = 4; wb_d = 32'hCC;
        run_cycle("prio_ex");
        chk("prio_ex.b", ex_b, 32'hAA);
        @(negedge clk);
        id_valid = 1; id_rnb = 4; id_qb = 32'h4; ex_res = 32'hAA;
        run_cycle("prio_mem");
        chk("prio_mem.b", ex_b, 32'hBB);
        @(negedge clk);
        mem_we = 0;
        run_cycle("prio_wb");
        chk("prio_wb.b", ex_b, 32'hCC);

        // Same stage feeding both operands, and MEM vs WB split across a/b.
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_rna = 6; id_rnb = 6; mem_we = 1; mem_wn = 6; mem_alu = 32'h66;
        run_cycle("both");
        chk("both.a", ex_a, 32'h66);
        chk("both.b", ex_b, 32'h66);
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_rna = 6; id_rnb = 7; mem_we = 1; mem_wn = 6; mem_alu = 32'h66;
        wb_we = 1; wb_wn = 7; wb_d = 32'h77;
        run_cycle("split");
        chk("split.a", ex_a, 32'h66);
        chk("split.b", ex_b, 32'h77);

        // Load-use: one bubble, then the loaded value comes from MEM.
        load_producer(5'd5, 1'b1);
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_use_a = 1; id_rna = 5; id_qa = 32'h5;
        #1;
        chk("lu.stall1", {31'b0, stall}, 32'd1);
        run_cycle("lu1");
        chk("lu1.valid", {31'b0, ex_valid}, 32'd0);
        @(negedge clk);
        mem_we = 1; mem_m2reg = 1; mem_wn = 5; mem_mdo = 32'h55; mem_alu = 32'h99;
        #1;
        chk("lu.stall2", {31'b0, stall}, 32'd0);
        run_cycle("lu2");
        chk("lu2.a", ex_a, 32'h55);

        // Register 0 is never forwarded, and a load to r0 never stalls.
        load_producer(5'd0, 1'b0);
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_use_a = 1; id_rna = 0; id_qa = 0; ex_res = 32'hFF;
        mem_we = 1; mem_wn = 0; mem_alu = 32'hFF; mem_mdo = 32'hFF;
        wb_we = 1; wb_wn = 0; wb_d = 32'hFF;
        run_cycle("r0");
        chk("r0.a", ex_a, 32'h0);
        load_producer(5'd0, 1'b1);
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_use_a = 1; id_rna = 0;
        #1;
        chk("r0.stall", {31'b0, stall}, 32'd0);
        run_cycle("r0ld");

        // Flush beats stall.
        load_producer(5'd5, 1'b1);
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_use_a = 1; id_rna = 5; ex_flush = 1;
        #1;
        chk("flush.stall", {31'b0, stall}, 32'd0);
        run_cycle("flush");
        chk("flush.valid", {31'b0, ex_valid}, 32'd0);

        // Async reset in the middle of a stall cycle.
        load_producer(5'd5, 1'b1);
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_use_b = 1; id_rnb = 5; id_qb = 32'h1234; id_wn = 9; id_we = 1;
        #1;
        chk("rst.pre_stall", {31'b0, stall}, 32'd1);
        clrn = 0;
        #1;
        model_clear();
        check_ex("rst.async");
        chk("rst.stall", {31'b0, stall}, 32'd0);
        #1;
        clrn = 1;
        run_cycle("rst.post");
        chk("rst.post.valid", {31'b0, ex_valid}, 32'd1);
        chk("rst.post.b", ex_b, 32'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
